// File: rtl/datapath_multiciclo.sv
// Multicycle datapath: register file, ALU and a control FSM that executes one
// instruction over several cycles against variable-latency req/ack memories.
module datapath_multiciclo #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] program_counter,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            overflow,
  output logic            retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SLTI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_SD   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(XLEN / 8 - 1);

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr;
  logic [3:0]      op_q;
  logic            ovf_pend;

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd_f   = ir[11:7];
  assign rs1_f  = ir[19:15];
  assign rs2_f  = ir[24:20];

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            use_rs1, use_rs2, use_rd;
  logic            is_ecall, bad_reg, misaligned, dec_illegal;
  logic [XLEN-1:0] rs1_val, rs2_val, mem_addr_d;

  always_comb begin
    dec_op  = OP_NONE;
    dec_imm = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == 7'b0000000 && funct3 == 3'b000)      dec_op = OP_ADD;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_op = OP_SUB;
        else if (funct7 == 7'b0000000 && funct3 == 3'b010) dec_op = OP_SLT;
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
        if (funct3 == 3'b000)      dec_op = OP_ADDI;
        else if (funct3 == 3'b010) dec_op = OP_SLTI;
      end
      7'b0000011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
        if (funct3 == 3'b011) dec_op = OP_LD;
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
        if (funct3 == 3'b011) dec_op = OP_SD;
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (funct3 == 3'b000) dec_op = OP_BEQ;
      end
      default: dec_op = OP_NONE;
    endcase
  end

  // Register indices beyond NREG read as zero; decode rejects them anyway.
  assign rs1_val    = (32'(rs1_f) < NREG) ? regs[rs1_f] : '0;
  assign rs2_val    = (32'(rs2_f) < NREG) ? regs[rs2_f] : '0;
  assign mem_addr_d = rs1_val + dec_imm;

  assign is_ecall    = (ir == 32'h0000_0073);
  assign bad_reg     = (use_rs1 && 32'(rs1_f) >= NREG) ||
                       (use_rs2 && 32'(rs2_f) >= NREG) ||
                       (use_rd  && 32'(rd_f)  >= NREG);
  assign misaligned  = ((dec_op == OP_LD) || (dec_op == OP_SD)) &&
                       (|(mem_addr_d & ALIGN_MASK));
  assign dec_illegal = (dec_op == OP_NONE) || bad_reg || misaligned;

  // ALU
  logic [XLEN-1:0] op_b, alu_sum, alu_diff, alu_res;
  logic            alu_ovf, beq_taken;

  assign op_b      = ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT)) ? b_q : imm_q;
  assign alu_sum   = a_q + op_b;
  assign alu_diff  = a_q - op_b;
  assign beq_taken = (a_q == b_q);

  always_comb begin
    alu_res = alu_sum;
    alu_ovf = (a_q[XLEN-1] == op_b[XLEN-1]) && (alu_sum[XLEN-1] != a_q[XLEN-1]);
    case (op_q)
      OP_SUB: begin
        alu_res = alu_diff;
        alu_ovf = (a_q[XLEN-1] != op_b[XLEN-1]) && (alu_diff[XLEN-1] != a_q[XLEN-1]);
      end
      OP_SLT, OP_SLTI: begin
        alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
        alu_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  logic retire_now;
  assign retire_now = (state == S_WB) ||
                      (state == S_EXEC && op_q == OP_BEQ) ||
                      (state == S_MEM && dmem_ack && op_q == OP_SD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alu_q    <= '0;
      mdr      <= '0;
      op_q     <= OP_NONE;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      retired  <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
    end else begin
      retired <= retire_now;
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_ecall) begin
            state <= S_HALT;
          end else if (dec_illegal) begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            imm_q <= dec_imm;
            op_q  <= dec_op;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q    <= alu_res;
          ovf_pend <= alu_ovf;
          if (op_q == OP_BEQ) begin
            pc    <= beq_taken ? pc + imm_q : pc + XLEN'(4);
            state <= S_FETCH;
          end else if (op_q == OP_LD || op_q == OP_SD) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op_q == OP_LD) begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end else begin
              pc    <= pc + XLEN'(4);
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (rd_f != 5'd0) regs[rd_f] <= (op_q == OP_LD) ? mdr : alu_q;
          if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_ADDI) overflow <= ovf_pend;
          pc    <= pc + XLEN'(4);
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req        = (state == S_FETCH);
  assign imem_addr       = pc;
  assign dmem_req        = (state == S_MEM);
  assign dmem_we         = dmem_req && (op_q == OP_SD);
  assign dmem_addr       = alu_q;
  assign dmem_wdata      = b_q;
  assign program_counter = pc;
  assign busy            = (state != S_IDLE) && (state != S_HALT);
  assign halted          = (state == S_HALT);

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Scoreboard bench for datapath_multiciclo: expected retirements and data
// accesses are queued by the stimulus and checked by an independent monitor.
module tb_datapath_multiciclo;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            imem_req, imem_ack;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [XLEN-1:0] program_counter;
  logic            busy, halted, illegal, overflow, retired;

  datapath_multiciclo #(.XLEN(XLEN), .NREG(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .program_counter(program_counter),
    .busy(busy), .halted(halted), .illegal(illegal), .overflow(overflow), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic ovf; int gap; } ret_t;
  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } acc_t;

  ret_t        ret_q[$];
  acc_t        acc_q[$];
  ret_t        re;
  acc_t        ae;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mark = 0;
  int          ilat = 0;
  int          dlat = 0;
  int          iw = 0;
  int          dw = 0;
  logic        dreq_prev = 1'b0;
  logic [31:0] imem [64];
  logic [63:0] dmem [64];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Instruction memory responder: ack after ilat wait cycles
  always @(negedge clk) begin
    if (reset && imem_req) begin
      if (iw >= ilat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem[imem_addr[7:2]];
        iw         = 0;
      end else begin
        imem_ack = 1'b0;
        iw++;
      end
    end else begin
      imem_ack = 1'b0;
      iw       = 0;
    end
  end

  always @(negedge clk) begin
    if (reset && dmem_req) begin
      if (dw >= dlat) begin
        dmem_ack = 1'b1;
        if (dmem_we) dmem[dmem_addr[8:3]] = dmem_wdata;
        else         dmem_rdata = dmem[dmem_addr[8:3]];
        dw = 0;
      end else begin
        dmem_ack = 1'b0;
        dw++;
      end
    end else begin
      dmem_ack = 1'b0;
      dw       = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      dreq_prev = 1'b0;
    end else begin
      if (retired) begin
        if (ret_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire actual_pc=%h required=none", program_counter);
        end else begin
          re = ret_q.pop_front();
          check64("retire_pc", program_counter, re.pc);
          check64("overflow", 64'(overflow), 64'(re.ovf));
          check64("latency", 64'(cyc - mark), 64'(re.gap));
          mark = cyc;
        end
      end
      if (dmem_req && !dreq_prev) begin
        if (acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dmem_req actual_addr=%h required=none", dmem_addr);
        end else begin
          ae = acc_q.pop_front();
          check64("dmem_we", 64'(dmem_we), 64'(ae.we));
          check64("dmem_addr", dmem_addr, ae.addr);
          if (ae.we) check64("dmem_wdata", dmem_wdata, ae.wdata);
        end
      end
      dreq_prev = dmem_req;
    end
  end

  task automatic exp_ret(input logic [63:0] pc, input logic ovf, input int gap);
    ret_t e;
    e.pc = pc; e.ovf = ovf; e.gap = gap;
    ret_q.push_back(e);
  endtask

  task automatic exp_acc(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    acc_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    acc_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ret_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_prog();
    @(negedge clk);
    start = 1'b1;
    mark  = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic wait_halt(input int budget, input logic exp_ill, input logic [63:0] exp_pc);
    int   n = 0;
    logic seen = 1'b0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check64("halted", 64'(halted), 64'h1);
    check64("illegal", 64'(illegal), 64'(exp_ill));
    check64("halt_pc", program_counter, exp_pc);
    check64("busy_in_halt", 64'(busy), 64'h0);
    check64("pending_retires", 64'(ret_q.size()), 64'h0);
    check64("pending_dmem", 64'(acc_q.size()), 64'h0);
    @(negedge clk);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      seen  = seen | imem_req | dmem_req | busy;
    end
    check64("activity_after_halt", 64'(seen), 64'h0);
    check64("still_halted", 64'(halted), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 64; i++) dmem[i] = 64'h0;

    // Program A: addi/addi/add, sd/ld with slow data memory, beq taken/not taken, ecall
    clear_imem();
    imem[0] = 32'h00500093; imem[1] = 32'hFFD00113; imem[2] = 32'h002081B3;
    imem[3] = 32'h00303423; imem[4] = 32'h00803203; imem[5] = 32'h00403823;
    imem[6] = 32'h00108463; imem[8] = 32'h00208463; imem[9] = 32'h00000073;

    // Reset state, then reset mid-run
    repeat (2) @(negedge clk);
    check64("rst_busy", 64'(busy), 64'h0);
    check64("rst_halted", 64'(halted), 64'h0);
    check64("rst_illegal", 64'(illegal), 64'h0);
    check64("rst_overflow", 64'(overflow), 64'h0);
    check64("rst_retired", 64'(retired), 64'h0);
    check64("rst_reqs", 64'({imem_req, dmem_req, dmem_we}), 64'h0);
    check64("rst_pc", program_counter, 64'h0);
    check64("rst_imem_addr", imem_addr, 64'h0);
    reset = 1'b1;
    ilat = 0; dlat = 0;
    start_prog();
    @(negedge clk);
    check64("midrun_busy_before", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check64("midrun_busy", 64'(busy), 64'h0);
    check64("midrun_pc", program_counter, 64'h0);
    check64("midrun_imem_req", 64'(imem_req), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check64("idle_no_start_busy", 64'(busy), 64'h0);
    check64("idle_no_start_req", 64'(imem_req), 64'h0);

    do_reset();
    ilat = 0; dlat = 3;
    exp_ret(64'd4, 1'b0, 4);  exp_ret(64'd8, 1'b0, 4);  exp_ret(64'd12, 1'b0, 4);
    exp_ret(64'd16, 1'b0, 7); exp_acc(1'b1, 64'd8, 64'd2);
    exp_ret(64'd20, 1'b0, 8); exp_acc(1'b0, 64'd8, 64'd0);
    exp_ret(64'd24, 1'b0, 7); exp_acc(1'b1, 64'd16, 64'd2);
    exp_ret(64'h20, 1'b0, 3); exp_ret(64'h24, 1'b0, 3);
    start_prog();
    wait_halt(300, 1'b0, 64'h24);

    // Program B: overflow, sub, slt/slti, x0 writes, slow fetch, ends on an illegal word
    do_reset();
    clear_imem();
    dmem[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    imem[0]  = 32'h7FF00293; imem[1]  = 32'h00003303; imem[2]  = 32'h00100393;
    imem[3]  = 32'h00730433; imem[4]  = 32'h00803023; imem[5]  = 32'h007284B3;
    imem[6]  = 32'h40740533; imem[7]  = 32'h007425B3; imem[8]  = 32'hFFF2A613;
    imem[9]  = 32'h00A03423; imem[10] = 32'h00B03823; imem[11] = 32'h00C03C23;
    imem[12] = 32'h02903023; imem[13] = 32'h00500013; imem[14] = 32'h02003423;
    imem[15] = 32'hFFFFFFFF;
    ilat = 2; dlat = 0;
    exp_ret(64'd4, 1'b0, 6);
    exp_ret(64'd8, 1'b0, 7);  exp_acc(1'b0, 64'd0, 64'd0);
    exp_ret(64'd12, 1'b0, 6);
    exp_ret(64'd16, 1'b1, 6);
    exp_ret(64'd20, 1'b1, 6); exp_acc(1'b1, 64'd0, 64'h8000_0000_0000_0000);
    exp_ret(64'd24, 1'b0, 6);
    exp_ret(64'd28, 1'b1, 6);
    exp_ret(64'd32, 1'b1, 6);
    exp_ret(64'd36, 1'b1, 6);
    exp_ret(64'd40, 1'b1, 6); exp_acc(1'b1, 64'd8, 64'h7FFF_FFFF_FFFF_FFFF);
    exp_ret(64'd44, 1'b1, 6); exp_acc(1'b1, 64'd16, 64'd1);
    exp_ret(64'd48, 1'b1, 6); exp_acc(1'b1, 64'd24, 64'd0);
    exp_ret(64'd52, 1'b1, 6); exp_acc(1'b1, 64'd32, 64'h800);
    exp_ret(64'd56, 1'b0, 6);
    exp_ret(64'd60, 1'b0, 6); exp_acc(1'b1, 64'd40, 64'd0);
    start_prog();
    wait_halt(400, 1'b1, 64'd60);

    // Program C: misaligned ld must halt without touching data memory
    do_reset();
    clear_imem();
    imem[0] = 32'h00403083;
    ilat = 0; dlat = 0;
    start_prog();
    wait_halt(50, 1'b1, 64'd0);

    do_reset();
    #1;
    check64("reset_clears_illegal", 64'(illegal), 64'h0);
    check64("reset_clears_halt", 64'(halted), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
